// File: rtl/pio_pkg.sv
// Shared register map and edge-mode encoding for the Avalon GPIO port.
// Imported by avalon_pio_edge and pio_sync_edge.
package pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_mode_e;

endpackage

// File: rtl/pio_sync_edge.sv
// Pin synchroniser, edge history and post-reset arming; o_event is combinational
// from the synchronised and history flops, held at zero until the chain has flushed.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int         WIDTH  = 16,
   parameter int         STAGES = 2,
   parameter edge_mode_e MODE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_pins,
   output logic [WIDTH-1:0] o_in_sync,
   output logic [WIDTH-1:0] o_event
);

   localparam logic [2:0] ARM_MAX = 3'(STAGES + 1);

   logic [WIDTH-1:0] r_sync [STAGES];
   logic [WIDTH-1:0] r_prev;
   logic [2:0]       r_arm_cnt;
   logic             w_armed;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
         r_prev    <= '0;
         r_arm_cnt <= '0;
      end else begin
         r_sync[0] <= i_pins;
         for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= r_sync[STAGES-1];
         if (r_arm_cnt != ARM_MAX) r_arm_cnt <= r_arm_cnt + 3'd1;
      end
   end

   assign o_in_sync = r_sync[STAGES-1];
   // Pins already high at reset would look like rising edges while the chain fills.
   assign w_armed   = (r_arm_cnt == ARM_MAX);
   assign w_rise    = r_sync[STAGES-1] & ~r_prev;
   assign w_fall    = ~r_sync[STAGES-1] & r_prev;

   always_comb begin
      o_event = '0;
      if (w_armed) begin
         case (MODE)
            EDGE_RISE: o_event = w_rise;
            EDGE_FALL: o_event = w_fall;
            default:   o_event = w_rise | w_fall;
         endcase
      end
   end

endmodule

// File: rtl/avalon_pio_edge.sv
// Avalon-MM GPIO: data/dir/irqmask/edge-capture registers, 1-cycle registered reads, no wait states.
// Optional OUTSET/OUTCLEAR atomic bit access at addresses 4/5 when PIO_BITSET_EN is defined.
module avalon_pio_edge
   import pio_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_MODE   = 0,
   parameter logic [31:0] RESET_OUT   = 32'h0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic [2:0]        address,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [DATA_W-1:0] oe_port,
   output logic              irq
);

   logic [DATA_W-1:0] r_data_out;
   logic [DATA_W-1:0] r_dir;
   logic [DATA_W-1:0] r_irqmask;
   logic [DATA_W-1:0] r_edgecap;

   logic              w_wr;
   logic [DATA_W-1:0] w_wdat;
   logic [DATA_W-1:0] w_clr;
   logic [DATA_W-1:0] w_in_sync;
   logic [DATA_W-1:0] w_event;
   logic [31:0]       w_rd;
   logic              w_unused;

   pio_sync_edge #(
      .WIDTH  (DATA_W),
      .STAGES (SYNC_STAGES),
      .MODE   (edge_mode_e'(EDGE_MODE))
   ) u_sync_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_pins    (in_port),
      .o_in_sync (w_in_sync),
      .o_event   (w_event)
   );

   assign w_wr     = chipselect & ~write_n;
   assign w_wdat   = writedata[DATA_W-1:0];
   assign w_unused = &{1'b0, writedata};
   assign w_clr    = (w_wr && address == ADDR_EDGECAP) ? w_wdat : '0;

   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA:    w_rd[DATA_W-1:0] = (r_dir & r_data_out) | (~r_dir & w_in_sync);
         ADDR_DIR:     w_rd[DATA_W-1:0] = r_dir;
         ADDR_IRQMASK: w_rd[DATA_W-1:0] = r_irqmask;
         ADDR_EDGECAP: w_rd[DATA_W-1:0] = r_edgecap;
         default:      w_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= RESET_OUT[DATA_W-1:0];
         r_dir      <= '0;
         r_irqmask  <= '0;
         r_edgecap  <= '0;
         readdata   <= '0;
         irq        <= 1'b0;
      end else begin
         readdata  <= w_rd;
         // Output-direction bits never capture; a new event beats a same-cycle clear.
         r_edgecap <= (r_edgecap & ~w_clr) | (w_event & ~r_dir);
         irq       <= |(r_edgecap & r_irqmask);
         if (w_wr) begin
            case (address)
               ADDR_DATA:    r_data_out <= w_wdat;
               ADDR_DIR:     r_dir      <= w_wdat;
               ADDR_IRQMASK: r_irqmask  <= w_wdat;
`ifdef PIO_BITSET_EN
               ADDR_OUTSET:  r_data_out <= r_data_out | w_wdat;
               ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdat;
`endif
               default: ;
            endcase
         end
      end
   end

   assign out_port = r_data_out;
   assign oe_port  = r_dir;

endmodule

// File: doc/avalon_pio_edge.md
Name: avalon_pio_edge

Overview:
Parametrised Avalon-MM general-purpose I/O port, the successor to our fixed 16-bit HPI data PIO. It adds the following:
- configurable width
- per-bit direction
- input synchroniser
- edge capture with write-1-to-clear
- masked interrupt output
It sits on the Qsys fabric between the Nios II and the off-chip USB HPI (CY7C67200) data/control pins, and is reusable for other GPIO.

Parameters:
DATA_W, 16, port width in bits (1..32)
SYNC_STAGES, 2, input synchroniser flops (2..4)
EDGE_MODE, 0, capture type: 0 rising, 1 falling, 2 any edge
RESET_OUT, 0, reset value of the output data register (DATA_W bits)

Ports:
clk  input  1  system clock
reset_n  input  1  reset
chipselect  input  1  Avalon slave select
address  input  3  register index
write_n  input  1  Avalon write strobe, active-low
writedata  input  32  write data; bits above DATA_W ignored
readdata  output  32  registered read data; upper bits zero
in_port  input  DATA_W  asynchronous pin inputs
out_port  output  DATA_W  output data register
oe_port  output  DATA_W  per-bit output enable (direction register)
irq  output  1  level interrupt

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Write qualifier: a write occurs when chipselect=1 and write_n=0. There are no wait states.
- Register map by address:
  - 0 DATA: read = (dir & data_out) | (~dir & in_sync); write loads data_out.
  - 1 DIR: 1 = output, read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; writing 1 to a bit clears that bit.
  - 4..7: read 0, writes ignored, unless PIO_BITSET_EN is defined (see Optional Feature).
- readdata is re-registered every clk from the address mux, independent of chipselect. Read latency is 1 cycle.
- Reset values:
  - data_out = RESET_OUT; dir = 0; irqmask = 0; edgecap = 0.
  - Synchroniser chain and edge-detect history flops = 0.
  - readdata = 0; irq = 0.
- Synchroniser: in_sync = in_port delayed SYNC_STAGES clocks. A pin change is visible on a DATA read no earlier than SYNC_STAGES+1 cycles later.
- Edge detect: in_prev <= in_sync each cycle.
  - rise = in_sync & ~in_prev; fall = ~in_sync & in_prev.
  - The event is selected by EDGE_MODE and masked by ~dir, so output bits never capture.
- Arming counter: counts SYNC_STAGES+1 cycles after reset release. Edge events are suppressed until it saturates, so pins that are high at reset do not produce spurious captures.
- edgecap: edgecap <= (edgecap & ~clr) | event. A set and a clear on the same bit in the same cycle leaves the bit set (set wins).
- irq = |(edgecap & irqmask), driven by a flop, so it asserts 1 cycle after the capture or mask change.
- out_port = data_out and oe_port = dir, both registered with no combinational path from the bus.
- Changing DIR from 1 to 0 does not generate an edge by itself; only subsequent in_sync transitions after that point do.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). Pending captures are lost and the arming counter restarts.

Optional Feature:
Macro PIO_BITSET_EN.
- Defined: address 4 OUTSET does data_out |= writedata; address 5 OUTCLEAR does data_out &= ~writedata. Both read 0. These give atomic bit manipulation for HPI strobes without read-modify-write. A simultaneous set and clear of the same bit cannot occur because they are single-port writes.
- Undefined: addresses 4 and 5 behave like 6 and 7 (read 0, writes ignored).

Decomposition:
- Package pio_pkg holds:
  - register address localparams: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3, ADDR_OUTSET=4, ADDR_OUTCLR=5
  - edge-mode enum constants: EDGE_RISE, EDGE_FALL, EDGE_ANY
- One sub-module is natural: pio_sync_edge. It is parametrised by width, stages and mode; it contains the synchroniser, history flops and arming counter, and outputs in_sync and event.

Test Plan:
- Reset with RESET_OUT=16'h00A5 and in_port=16'hFFFF → out_port=00A5, oe_port=0, irq=0, and EDGECAP reads 0 after 10 cycles (arming blocks the spurious edges).
- Write DIR=16'h00FF, DATA=16'h1234, with in_port=16'hAB00 → DATA read = 16'hAB34, one cycle after the read address is presented.
- EDGE_MODE=0, IRQMASK=16'h0100: pulse in_port[8] 0→1 → EDGECAP bit 8 set at cycle 3, irq=1 at cycle 4; write EDGECAP=16'h0100 → bit clears and irq falls the next cycle.
- Clear bit 8 in the same cycle that a new rising edge on bit 8 reaches the detector → bit 8 remains 1 and irq stays high.
- Pulse an edge on a bit with DIR=1 → no capture, irq stays 0. Assert reset_n=0 mid-capture → all registers return to reset values within the same cycle.
- With PIO_BITSET_EN defined and DATA=16'h00F0: OUTSET 16'h0003 then OUTCLEAR 16'h0010 → out_port=16'h00E3. With the macro undefined, the same writes leave out_port=16'h00F0.
